// File: rtl/vdp_pkg.sv
// vdp_pkg: shared encodings for the VDP CPU-side controller.
package vdp_pkg;
    localparam int TBL_W = 14;
    localparam logic [1:0] MODE_TEXT = 2'd0;
    localparam logic [1:0] MODE_G1   = 2'd1;
    localparam logic [1:0] MODE_G2   = 2'd2;
    localparam logic [1:0] MODE_MC   = 2'd3;
    localparam logic [2:0] R_MODE0  = 3'd0;
    localparam logic [2:0] R_MODE1  = 3'd1;
    localparam logic [2:0] R_NAME   = 3'd2;
    localparam logic [2:0] R_COLTBL = 3'd3;
    localparam logic [2:0] R_FONT   = 3'd4;
    localparam logic [2:0] R_SATTR  = 3'd5;
    localparam logic [2:0] R_SPAT   = 3'd6;
    localparam logic [2:0] R_COLOR  = 3'd7;
    localparam int SH_NAME = 10;
    localparam int SH_COL  = 6;
    localparam int SH_FONT = 11;
    localparam int SH_G2   = 13;
    localparam int SH_SATTR = 7;
    localparam int SH_SPAT = 11;
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP} acc_state_t;
endpackage

// File: rtl/vdp_regfile.sv
// vdp_regfile: R0-R7 storage and combinational decode into video configuration.
module vdp_regfile
    import vdp_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_we,
    input  logic [2:0]       i_idx,
    input  logic [7:0]       i_data,
    output logic [1:0]       o_mode,
    output logic             o_video_on,
    output logic             o_vert_retrace_int,
    output logic             o_sprite_large,
    output logic             o_sprite_enlarged,
    output logic [TBL_W-1:0] o_name_table_addr,
    output logic [TBL_W-1:0] o_color_table_addr,
    output logic [TBL_W-1:0] o_font_addr,
    output logic [TBL_W-1:0] o_sprite_attr_addr,
    output logic [TBL_W-1:0] o_sprite_pattern_table_addr,
    output logic [3:0]       o_text_color,
    output logic [3:0]       o_back_color
);
    logic [7:0] r_regs [NUM_REGS];
    logic       w_g2;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_idx] <= i_data;
        end
    end

    // Text bit overrides multicolor, which overrides the graphics I/II select.
    always_comb begin
        o_mode = r_regs[R_MODE1][4] ? MODE_TEXT : r_regs[R_MODE1][3] ? MODE_MC :
                 r_regs[R_MODE0][1] ? MODE_G2 : MODE_G1;
        w_g2 = o_mode == MODE_G2;
        o_video_on = r_regs[R_MODE1][6];
        o_vert_retrace_int = r_regs[R_MODE1][5];
        o_sprite_large = r_regs[R_MODE1][1];
        o_sprite_enlarged = r_regs[R_MODE1][0];
        o_name_table_addr = TBL_W'(r_regs[R_NAME][3:0]) << SH_NAME;
        o_color_table_addr = w_g2 ? TBL_W'(r_regs[R_COLTBL][7]) << SH_G2 :
                                    TBL_W'(r_regs[R_COLTBL]) << SH_COL;
        o_font_addr = w_g2 ? TBL_W'(r_regs[R_FONT][2]) << SH_G2 :
                             TBL_W'(r_regs[R_FONT][2:0]) << SH_FONT;
        o_sprite_attr_addr = TBL_W'(r_regs[R_SATTR][6:0]) << SH_SATTR;
        o_sprite_pattern_table_addr = TBL_W'(r_regs[R_SPAT][2:0]) << SH_SPAT;
        o_text_color = r_regs[R_COLOR][7:4];
        o_back_color = r_regs[R_COLOR][3:0];
    end
endmodule

// File: rtl/vdp_ctrl.sv
// vdp_ctrl: CPU data/control port sequencer, VRAM pointer with read-ahead, status and interrupt.
module vdp_ctrl
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_port,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic              vram_rd,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    input  logic              interrupt_flag,
    input  logic              sprite_collision,
    input  logic              too_many_sprites,
    input  logic [4:0]        sprite5,
    output logic [1:0]        mode,
    output logic              video_on,
    output logic              vert_retrace_int,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [TBL_W-1:0]  name_table_addr,
    output logic [TBL_W-1:0]  color_table_addr,
    output logic [TBL_W-1:0]  font_addr,
    output logic [TBL_W-1:0]  sprite_attr_addr,
    output logic [TBL_W-1:0]  sprite_pattern_table_addr,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    output logic              n_int
);
    acc_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rbuf, r_latch, r_dout, r_wdata;
    logic              r_toggle, r_wr, r_clr, r_f, r_c, r_5s;
    logic [4:0]        r_num5;
    logic              w_wr, w_rd, w_ctl2, w_pf;

    // Write beats read when both strobes arrive together.
    assign w_wr   = cpu_wr & !busy;
    assign w_rd   = cpu_rd & !cpu_wr & !busy;
    assign w_ctl2 = w_wr & cpu_port & r_toggle;
    assign w_pf   = (w_ctl2 & cpu_din[7:6] == 2'b00) | (w_rd & !cpu_port);

    assign cpu_dout   = r_dout;
    assign vram_addr  = r_addr;
    assign vram_wr    = r_wr;
    assign vram_wdata = r_wdata;
    assign n_int      = !(r_f & vert_retrace_int);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == IDLE ? (w_pf ? RD_ISSUE : IDLE) :
                 r_state == RD_ISSUE ? RD_CAP : IDLE;
    end

    always_comb begin
        vram_rd = r_state == RD_ISSUE;
        busy = r_state != IDLE || r_wr;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_addr <= '0;
            r_rbuf <= '0;
            r_latch <= '0;
            r_dout <= '0;
            r_wdata <= '0;
            r_toggle <= 1'b0;
            r_wr <= 1'b0;
            r_clr <= 1'b0;
            r_f <= 1'b0;
            r_c <= 1'b0;
            r_5s <= 1'b0;
            r_num5 <= '0;
        end else begin
            r_wr <= w_wr & !cpu_port;
            r_clr <= w_rd & cpu_port;
            if (w_wr & !cpu_port) r_wdata <= cpu_din;
            if (w_wr) r_toggle <= cpu_port & !r_toggle;
            if (w_rd) r_toggle <= 1'b0;
            if (w_wr & cpu_port & !r_toggle) r_latch <= cpu_din;
            if (w_ctl2 & !cpu_din[7]) r_addr <= ADDR_W'({cpu_din[5:0], r_latch});
            if (r_wr) begin
                r_rbuf <= r_wdata;
                r_addr <= r_addr + 1'b1;
            end
            if (r_state == RD_CAP) begin
                r_rbuf <= vram_rdata;
                r_addr <= r_addr + 1'b1;
            end
            if (w_rd) r_dout <= cpu_port ? {r_f, r_5s, r_c, r_num5} : r_rbuf;
            // A new event in the clear cycle survives the clear.
            r_f <= interrupt_flag | (r_f & !r_clr);
            r_c <= sprite_collision | (r_c & !r_clr);
            if (too_many_sprites & (!r_5s | r_clr)) begin
                r_5s <= 1'b1;
                r_num5 <= sprite5;
            end else if (r_clr) begin
                r_5s <= 1'b0;
                r_num5 <= 5'h1f;
            end
        end
    end

    vdp_regfile #(.NUM_REGS(NUM_REGS)) u_regs (
        .clk                         (clk),
        .n_reset                     (n_reset),
        .i_we                        (w_ctl2 & cpu_din[7]),
        .i_idx                       (cpu_din[2:0]),
        .i_data                      (r_latch),
        .o_mode                      (mode),
        .o_video_on                  (video_on),
        .o_vert_retrace_int          (vert_retrace_int),
        .o_sprite_large              (sprite_large),
        .o_sprite_enlarged           (sprite_enlarged),
        .o_name_table_addr           (name_table_addr),
        .o_color_table_addr          (color_table_addr),
        .o_font_addr                 (font_addr),
        .o_sprite_attr_addr          (sprite_attr_addr),
        .o_sprite_pattern_table_addr (sprite_pattern_table_addr),
        .o_text_color                (text_color),
        .o_back_color                (back_color)
    );
endmodule

// File: doc/vdp_ctrl.md
Name: vdp_ctrl

Overview:
- CPU-side controller for the TMS9918-style video block: decodes the data port and the control port (0x98/0x99 style).
- Sequences the two-byte control protocol and owns the 14-bit VRAM address pointer with auto-increment and a one-byte read-ahead buffer.
- Holds VDP registers R0–R7, derives every configuration input of the video datapath, and maintains the status register and interrupt line.

Parameters:
- ADDR_W, 14, VRAM address width.
- NUM_REGS, 8, number of write-only VDP registers.

Ports:
- clk  in  1  system clock; VRAM port A is driven in this domain.
- n_reset  in  1  asynchronous, active-low reset.
- cpu_wr  in  1  one-cycle write strobe from the CPU bus.
- cpu_rd  in  1  one-cycle read strobe from the CPU bus.
- cpu_port  in  1  0 = data port, 1 = control/status port.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- busy  out  1  VRAM access in progress; strobes are ignored while high.
- vram_addr  out  14  VRAM address.
- vram_wr  out  1  VRAM write strobe.
- vram_rd  out  1  VRAM read strobe.
- vram_wdata  out  8  VRAM write data.
- vram_rdata  in  8  VRAM read data, valid 1 cycle after vram_rd.
- interrupt_flag  in  1  frame-end pulse from the video block.
- sprite_collision  in  1  collision indication from the video block.
- too_many_sprites  in  1  fifth-sprite indication from the video block.
- sprite5  in  5  fifth-sprite number from the video block.
- mode  out  2  0 text, 1 graphics I, 2 graphics II, 3 multicolor.
- video_on, vert_retrace_int, sprite_large, sprite_enlarged  out  1 each  control bits.
- name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each  table base addresses.
- text_color, back_color  out  4 each  colors.
- n_int  out  1  active-low CPU interrupt.

Behaviour:
- Reset (n_reset low, asynchronous):
  - R0–R7 = 0, addr = 0, rbuf = 0, toggle = 0.
  - Status S = 0; state IDLE; cpu_dout = 0.
  - vram_wr = vram_rd = 0, busy = 0, n_int = 1.
  - Reset mid-access aborts it; no VRAM strobe is issued after release.
- Arbitration between strobes:
  - Strobes are accepted only when busy = 0.
  - If cpu_wr and cpu_rd are asserted together, the write wins and the read is dropped.
- Control write, first byte (toggle = 0): latch = cpu_din; toggle -> 1.
- Control write, second byte (toggle = 1); toggle -> 0 in every case:
  - b[7] = 1: write R[b[2:0]] <= latch.
  - b[7:6] = 01: addr <= {b[5:0], latch}; no read.
  - b[7:6] = 00: addr <= {b[5:0], latch}, then prefetch.
- Prefetch sequence:
  - IDLE -> RD_ISSUE: vram_rd = 1 for one cycle with vram_addr = addr; busy = 1.
  - RD_ISSUE -> RD_CAP: rbuf <= vram_rdata; addr <= addr + 1; busy = 1.
  - RD_CAP -> IDLE.
  - Total busy time is 2 cycles.
- Data write: vram_wr = 1 for one cycle with vram_addr = addr and vram_wdata = cpu_din. Next cycle: rbuf <= cpu_din, addr++. toggle -> 0. busy for 1 cycle.
- Data read: cpu_dout <= rbuf on the cycle after the strobe, held until the next read; then prefetch; toggle -> 0.
- Status read:
  - cpu_dout <= {F, 5S, C, num5}; toggle -> 0.
  - Next cycle: F, C and 5S clear; num5 <= 5'h1f.
- Address pointer: 14-bit, 0x3FFF + 1 wraps to 0x0000.
- Status bits:
  - F: set on interrupt_flag.
  - C: set on sprite_collision.
  - 5S and num5: set on too_many_sprites while 5S = 0 (num5 <= sprite5).
  - All three are sticky. A set in the same cycle as a status-read clear wins.
- n_int = !(F & R1[5]).
- Register decode:
  - mode: R1[4] ? 0 : R1[3] ? 3 : R0[1] ? 2 : 1.
  - video_on = R1[6]; vert_retrace_int = R1[5]; sprite_large = R1[1]; sprite_enlarged = R1[0].
  - name_table_addr = {R2[3:0], 10'b0}.
  - color_table_addr: mode 2 -> {R3[7], 13'b0}, otherwise {R3, 6'b0}.
  - font_addr: mode 2 -> {R4[2], 13'b0}, otherwise {R4[2:0], 11'b0}.
  - sprite_attr_addr = {R5[6:0], 7'b0}; sprite_pattern_table_addr = {R6[2:0], 11'b0}.
  - text_color = R7[7:4]; back_color = R7[3:0].
  - All decode outputs are combinational from the registers.

Decomposition:
- Package vdp_pkg:
  - Mode encodings (MODE_TEXT = 0, MODE_G1 = 1, MODE_G2 = 2, MODE_MC = 3).
  - Register indices R_MODE0..R_COLOR.
  - Access state enum IDLE/RD_ISSUE/RD_CAP.
  - Table-base shift constants.
- One sub-module, vdp_regfile: R0–R7 storage plus combinational decode to table addresses and modes. The port sequencer stays in vdp_ctrl.

Test Plan:
- Control writes 0x00 then 0x47 -> vram_wr=1 at addr 0x0700 with cpu_din = 0x55; then 0x3FFF writes -> addr wraps to 0x0000.
- Control writes 0x0F, 0x82 -> name_table_addr = 0x3C00. Then 0xE0, 0x81 -> video_on = 1, vert_retrace_int = 1, mode = 1. Then 0x02, 0x80 -> mode = 2.
- Control writes 0x34, 0x12 -> vram_rd at 0x1234. VRAM returns 0xA5; data read -> cpu_dout = 0xA5, next prefetch at 0x1235, addr = 0x1236.
- Single control write 0x12, then status read, then control writes 0x00, 0x40 -> toggle was reset, addr = 0x0000, no register written.
- R1[5] = 1, pulse interrupt_flag -> n_int = 0. Status read -> cpu_dout[7] = 1, n_int = 1 next cycle. interrupt_flag in the same cycle as the read -> F stays 1.
- too_many_sprites with sprite5 = 5'd7 -> status reads 0x47 (C = 0). A second event with sprite5 = 5'd9 before the read -> still 0x47.
- n_reset low during RD_ISSUE -> busy = 0 and outputs at reset values asynchronously; no rbuf update after release.
